mem_arb: RTL and testbench
==========================

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter TIMEOUT, default 255, meaning max cycles in REQ+RSP before a forced error response (1..255).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 ifu_req_valid  input  1  fetch request pending.
REQ-005 ifu_req_ready  output  1  fetch request accepted this cycle.
REQ-006 ifu_addr  input  32  fetch address.
REQ-007 ifu_rsp_valid  output  1  one-cycle fetch response pulse.
REQ-008 ifu_rsp_err  output  1  fetch response is a timeout error.
REQ-009 ifu_rdata  output  32  fetched instruction word.
REQ-010 lsu_req_valid  input  1  load/store request pending.
REQ-011 lsu_req_ready  output  1  load/store request accepted this cycle.
REQ-012 lsu_addr  input  32  load/store address.
REQ-013 lsu_wen  input  1  1 = store, 0 = load.
REQ-014 lsu_wdata  input  32  store data.
REQ-015 lsu_wmask  input  4  store byte-enable.
REQ-016 lsu_rsp_valid  output  1  one-cycle load/store response pulse.
REQ-017 lsu_rsp_err  output  1  load/store response is a timeout error.
REQ-018 lsu_rdata  output  32  load data; 0 for stores.
REQ-019 mem_req_valid  output  1  request to shared memory port.
REQ-020 mem_req_ready  input  1  memory accepts the request.
REQ-021 mem_addr, mem_wen, mem_wdata, mem_wmask  output  32/1/32/4  registered copy of the granted request.
REQ-022 mem_rsp_valid  input  1  memory response valid.
REQ-023 mem_rdata  input  32  memory response data.

Function
REQ-024 FSM states: IDLE, REQ, RSP, DONE; one transaction outstanding at a time.
REQ-025 IDLE: the winner's xx_req_ready is high combinationally; all other cycles both readies are 0.
REQ-026 Arbitration is round-robin; when only one requester is valid it wins; when both are valid, the one not in last_grant wins.
REQ-027 On acceptance: capture addr/wen/wdata/wmask and owner, update last_grant, clear the timeout counter, go to REQ.
REQ-028 IFU grants register mem_wen=0 and mem_wmask=0; LSU loads register mem_wmask=0 regardless of lsu_wmask.
REQ-029 REQ: mem_req_valid=1 with stable fields; when mem_req_ready=1, go to RSP.
REQ-030 RSP: when mem_rsp_valid=1, register mem_rdata (0 if store), err=0, go to DONE.
REQ-031 The timeout counter is 8 bits and increments every cycle in REQ or RSP; if it equals TIMEOUT-1 without completion, go to DONE with err=1, rdata=0, and drop mem_req_valid.
REQ-032 DONE: the owner's rsp_valid=1 for exactly one cycle with the registered rdata/err, then go to IDLE.
REQ-033 The non-owner's rsp_valid and rsp_err are always 0; rdata outputs hold their last value.
REQ-034 mem_rsp_valid outside RSP is ignored.
REQ-035 A simultaneous mem_rsp_valid and timeout in the same cycle is treated as a normal response with err=0.
REQ-036 Minimum latency is accept at T, mem_req_valid at T+1, rsp pulse at T+3 (ready and rsp each in 1 cycle), next accept at T+4.

Reset
REQ-037 Reset asserted at any time forces IDLE, last_grant=LSU, counter=0, and all outputs to 0; any in-flight transaction is dropped with no response.
REQ-038 The first cycle after reset with both requesters valid grants the IFU.

Verification
REQ-039 IFU only, addr 0x80000000, memory ready/rsp after 1 cycle with rdata 0x00100073 -> ifu_req_ready at T, ifu_rsp_valid at T+3 with 0x00100073, err=0.
REQ-040 Both valid continuously -> grants alternate IFU, LSU, IFU, LSU; no starvation.
REQ-041 LSU store addr 0x80001000, wdata 0xDEADBEEF, wmask 0xF -> mem fields match exactly; lsu_rdata=0; lsu_rsp_valid is one pulse.
REQ-042 TIMEOUT=4 with memory never responding -> lsu_rsp_valid with err=1, rdata=0 four cycles after acceptance; then IDLE.
REQ-043 Reset asserted in RSP -> outputs are 0 immediately (asynchronous); a late mem_rsp_valid produces no rsp pulse; the next both-valid cycle grants IFU.
REQ-044 mem_req_ready held low 3 cycles -> mem_addr/mem_wdata stable throughout; no second acceptance.

Source files
------------

// File: rtl/mem_arb.sv
// -----------------------------------------------------------------------------
// mem_arb -- round-robin arbiter between an instruction fetch unit (IFU) and a
// load/store unit (LSU) sharing a single memory port. Only one transaction is
// in flight at a time; a transaction that stalls in the memory for too long is
// completed with an error response.
//
// Parameters
//   TIMEOUT        1..255, bounds the cycles a transaction may spend waiting
//                  on the memory before it is forced to an error response.
// Ports
//   clk, reset     rising-edge clock, asynchronous active-high reset
//   ifu_*          fetch request (valid/ready/addr) and response (valid/err/rdata)
//   lsu_*          load/store request (valid/ready/addr/wen/wdata/wmask) and
//                  response (valid/err/rdata; rdata is 0 for stores)
//   mem_*          shared memory request (valid/ready/addr/wen/wdata/wmask)
//                  and response (valid/rdata)
// -----------------------------------------------------------------------------
module mem_arb #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_rsp_valid,
    output logic        ifu_rsp_err,
    output logic [31:0] ifu_rdata,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_rsp_valid,
    output logic        lsu_rsp_err,
    output logic [31:0] lsu_rdata,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // The counter holds the number of REQ/RSP cycles already completed, so the
    // timeout fires during the (TIMEOUT-1)th waiting cycle and the error pulse
    // lands TIMEOUT cycles after acceptance. At least one REQ cycle always
    // happens, so TIMEOUT values below 2 collapse onto that single cycle.
    localparam logic [7:0] TO_LAST = (TIMEOUT < 32'd2) ? 8'd0 : 8'(TIMEOUT - 32'd2);

    state_t      state_r;
    state_t      state_s;
    logic        last_lsu_r;
    logic        owner_lsu_r;
    logic [7:0]  tmo_cnt_r;
    logic        grant_ifu_s;
    logic        grant_lsu_s;
    logic        accept_s;
    logic        timeout_s;
    logic        done_s;
    logic        done_err_s;
    logic [31:0] done_rdata_s;

    logic        mem_req_valid_r;
    logic [31:0] mem_addr_r;
    logic        mem_wen_r;
    logic [31:0] mem_wdata_r;
    logic [3:0]  mem_wmask_r;
    logic        ifu_rsp_valid_r;
    logic        ifu_rsp_err_r;
    logic [31:0] ifu_rdata_r;
    logic        lsu_rsp_valid_r;
    logic        lsu_rsp_err_r;
    logic [31:0] lsu_rdata_r;

    // Round-robin grant; readies are held low while reset is asserted so every
    // output reads 0 during reset even though the FSM sits in IDLE.
    always_comb begin
        grant_ifu_s = 1'b0;
        grant_lsu_s = 1'b0;
        if ((state_r == ST_IDLE) && !reset) begin
            grant_ifu_s = ifu_req_valid && (!lsu_req_valid || last_lsu_r);
            grant_lsu_s = lsu_req_valid && (!ifu_req_valid || !last_lsu_r);
        end else begin
            grant_ifu_s = 1'b0;
            grant_lsu_s = 1'b0;
        end
    end

    assign accept_s      = grant_ifu_s || grant_lsu_s;
    assign timeout_s     = (tmo_cnt_r == TO_LAST);
    assign ifu_req_ready = grant_ifu_s;
    assign lsu_req_ready = grant_lsu_s;

    // Next-state logic plus completion decode. A response arriving in the same
    // cycle as the timeout counts as a normal completion.
    always_comb begin
        state_s      = state_r;
        done_s       = 1'b0;
        done_err_s   = 1'b0;
        done_rdata_s = 32'd0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (timeout_s) begin
                    state_s    = ST_DONE;
                    done_s     = 1'b1;
                    done_err_s = 1'b1;
                end else if (mem_req_ready) begin
                    state_s = ST_RSP;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_RSP: begin
                if (mem_rsp_valid) begin
                    state_s      = ST_DONE;
                    done_s       = 1'b1;
                    done_rdata_s = mem_wen_r ? 32'd0 : mem_rdata;
                end else if (timeout_s) begin
                    state_s    = ST_DONE;
                    done_s     = 1'b1;
                    done_err_s = 1'b1;
                end else begin
                    state_s = ST_RSP;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, arbitration history, timeout counter and captured request fields.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            last_lsu_r      <= 1'b1;
            owner_lsu_r     <= 1'b0;
            tmo_cnt_r       <= 8'd0;
            mem_req_valid_r <= 1'b0;
            mem_addr_r      <= 32'd0;
            mem_wen_r       <= 1'b0;
            mem_wdata_r     <= 32'd0;
            mem_wmask_r     <= 4'd0;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                last_lsu_r      <= grant_lsu_s;
                owner_lsu_r     <= grant_lsu_s;
                tmo_cnt_r       <= 8'd0;
                mem_req_valid_r <= 1'b1;
                mem_addr_r      <= grant_lsu_s ? lsu_addr : ifu_addr;
                mem_wen_r       <= grant_lsu_s && lsu_wen;
                mem_wdata_r     <= grant_lsu_s ? lsu_wdata : 32'd0;
                mem_wmask_r     <= (grant_lsu_s && lsu_wen) ? lsu_wmask : 4'd0;
            end else begin
                if ((state_r == ST_REQ) || (state_r == ST_RSP)) begin
                    tmo_cnt_r <= tmo_cnt_r + 8'd1;
                end else begin
                    tmo_cnt_r <= tmo_cnt_r;
                end
                // Request leaves the port on handshake or when abandoned.
                if ((state_r == ST_REQ) && (mem_req_ready || timeout_s)) begin
                    mem_req_valid_r <= 1'b0;
                end else begin
                    mem_req_valid_r <= mem_req_valid_r;
                end
            end
        end
    end

    // Response pulses go only to the owner; rdata holds between responses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ifu_rsp_valid_r <= 1'b0;
            ifu_rsp_err_r   <= 1'b0;
            ifu_rdata_r     <= 32'd0;
            lsu_rsp_valid_r <= 1'b0;
            lsu_rsp_err_r   <= 1'b0;
            lsu_rdata_r     <= 32'd0;
        end else begin
            ifu_rsp_valid_r <= done_s && !owner_lsu_r;
            ifu_rsp_err_r   <= done_s && !owner_lsu_r && done_err_s;
            lsu_rsp_valid_r <= done_s && owner_lsu_r;
            lsu_rsp_err_r   <= done_s && owner_lsu_r && done_err_s;
            if (done_s && !owner_lsu_r) begin
                ifu_rdata_r <= done_rdata_s;
            end else begin
                ifu_rdata_r <= ifu_rdata_r;
            end
            if (done_s && owner_lsu_r) begin
                lsu_rdata_r <= done_rdata_s;
            end else begin
                lsu_rdata_r <= lsu_rdata_r;
            end
        end
    end

    assign mem_req_valid = mem_req_valid_r;
    assign mem_addr      = mem_addr_r;
    assign mem_wen       = mem_wen_r;
    assign mem_wdata     = mem_wdata_r;
    assign mem_wmask     = mem_wmask_r;
    assign ifu_rsp_valid = ifu_rsp_valid_r;
    assign ifu_rsp_err   = ifu_rsp_err_r;
    assign ifu_rdata     = ifu_rdata_r;
    assign lsu_rsp_valid = lsu_rsp_valid_r;
    assign lsu_rsp_err   = lsu_rsp_err_r;
    assign lsu_rdata     = lsu_rdata_r;

endmodule

// File: tb/tb_mem_arb.sv
// -----------------------------------------------------------------------------
// tb_mem_arb -- self-checking bench for mem_arb (TIMEOUT = 4).
// The bench plays the memory: for every accepted transaction it picks a
// ready delay and a response delay, and a transaction-level model predicts
// the grant, the exact response cycle (normal or timeout), the response
// contents and the memory-port fields from those delays.
// -----------------------------------------------------------------------------
module tb_mem_arb;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid, lsu_rsp_err;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    mem_arb #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_err(ifu_rsp_err), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_err(lsu_rsp_err), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Single comparison point for the whole bench.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Transaction-level model state.
    int          cyc;
    bit          busy;
    int          t_acc, rdy_cyc, rsp_cyc, p_cyc;
    bit          own_lsu, exp_err, last_lsu;
    logic [31:0] exp_rd, cur_mem_val;
    logic [31:0] m_addr, m_wdata;
    logic        m_wen;
    logic [3:0]  m_wmask;
    logic [31:0] ifu_hold, lsu_hold;

    // Request data offered in the next cycle.
    logic [31:0] n_ifu_addr, n_lsu_addr, n_lsu_wdata, n_mem_val;
    logic        n_lsu_wen;
    logic [3:0]  n_lsu_wmask;

    task automatic rand_data();
        n_ifu_addr  = $urandom;
        n_lsu_addr  = $urandom;
        n_lsu_wen   = 1'($urandom_range(0, 1));
        n_lsu_wdata = $urandom;
        n_lsu_wmask = 4'($urandom_range(0, 15));
        n_mem_val   = $urandom;
    endtask

    task automatic model_reset();
        busy     = 1'b0;
        last_lsu = 1'b1;
        ifu_hold = 32'd0;
        lsu_hold = 32'd0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ifu_ready"}, {31'd0, ifu_req_ready}, 32'd0);
        check({tag, "_lsu_ready"}, {31'd0, lsu_req_ready}, 32'd0);
        check({tag, "_rsp_flags"}, {28'd0, ifu_rsp_valid, ifu_rsp_err, lsu_rsp_valid, lsu_rsp_err}, 32'd0);
        check({tag, "_ifu_rdata"}, ifu_rdata, 32'd0);
        check({tag, "_lsu_rdata"}, lsu_rdata, 32'd0);
        check({tag, "_mem_req_valid"}, {31'd0, mem_req_valid}, 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check({tag, "_mem_wen_wmask"}, {27'd0, mem_wen, mem_wmask}, 32'd0);
    endtask

    // One clock cycle: check registered outputs, drive inputs, check readies,
    // and on a predicted acceptance schedule the memory behaviour.
    task automatic step(input bit iv, input bit lv, input int d1, input int d2, input bit spur);
        bit mreq, win, gi, gl;
        @(negedge clk);
        cyc++;
        if (busy && cyc > p_cyc) busy = 1'b0;
        if (busy && cyc == p_cyc) begin
            if (own_lsu) lsu_hold = exp_rd;
            else         ifu_hold = exp_rd;
        end
        check("ifu_rsp_valid", {31'd0, ifu_rsp_valid}, {31'd0, busy && cyc == p_cyc && !own_lsu});
        check("ifu_rsp_err",   {31'd0, ifu_rsp_err},   {31'd0, busy && cyc == p_cyc && !own_lsu && exp_err});
        check("lsu_rsp_valid", {31'd0, lsu_rsp_valid}, {31'd0, busy && cyc == p_cyc && own_lsu});
        check("lsu_rsp_err",   {31'd0, lsu_rsp_err},   {31'd0, busy && cyc == p_cyc && own_lsu && exp_err});
        check("ifu_rdata", ifu_rdata, ifu_hold);
        check("lsu_rdata", lsu_rdata, lsu_hold);
        mreq = busy && cyc > t_acc && cyc <= rdy_cyc && cyc < p_cyc;
        check("mem_req_valid", {31'd0, mem_req_valid}, {31'd0, mreq});
        if (busy && cyc > t_acc) begin
            check("mem_addr", mem_addr, m_addr);
            check("mem_wen_wmask", {27'd0, mem_wen, mem_wmask}, {27'd0, m_wen, m_wmask});
            if (own_lsu) check("mem_wdata", mem_wdata, m_wdata);
        end
        // Drive this cycle's inputs.
        ifu_req_valid = iv;
        lsu_req_valid = lv;
        ifu_addr      = n_ifu_addr;
        lsu_addr      = n_lsu_addr;
        lsu_wen       = n_lsu_wen;
        lsu_wdata     = n_lsu_wdata;
        lsu_wmask     = n_lsu_wmask;
        win           = busy && cyc > rdy_cyc && cyc < p_cyc;
        mem_req_ready = busy && cyc == rdy_cyc && cyc < p_cyc;
        mem_rsp_valid = (busy && cyc == rsp_cyc && cyc < p_cyc) || (spur && !win);
        mem_rdata     = (busy && cyc == rsp_cyc) ? cur_mem_val : $urandom;
        #1;
        gi = !busy && iv && (!lv || last_lsu);
        gl = !busy && lv && (!iv || !last_lsu);
        check("ifu_req_ready", {31'd0, ifu_req_ready}, {31'd0, gi});
        check("lsu_req_ready", {31'd0, lsu_req_ready}, {31'd0, gl});
        if (gi || gl) begin
            busy        = 1'b1;
            t_acc       = cyc;
            own_lsu     = gl;
            last_lsu    = gl;
            m_addr      = gl ? n_lsu_addr : n_ifu_addr;
            m_wen       = gl && n_lsu_wen;
            m_wdata     = n_lsu_wdata;
            m_wmask     = (gl && n_lsu_wen) ? n_lsu_wmask : 4'd0;
            cur_mem_val = n_mem_val;
            rdy_cyc     = cyc + 1 + d1;
            rsp_cyc     = rdy_cyc + 1 + d2;
            if (rsp_cyc + 1 <= cyc + TO) begin
                p_cyc   = rsp_cyc + 1;
                exp_err = 1'b0;
                exp_rd  = m_wen ? 32'd0 : n_mem_val;
            end else begin
                p_cyc   = cyc + TO;
                exp_err = 1'b1;
                exp_rd  = 32'd0;
            end
        end
    endtask

    task automatic idle(input int n, input bit iv, input bit lv);
        for (int i = 0; i < n; i++) begin
            rand_data();
            step(iv, lv, 0, 0, 1'b0);
        end
    endtask

    initial begin
        reset = 1'b1;
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
        ifu_addr = 32'd0; lsu_addr = 32'd0; lsu_wen = 1'b0; lsu_wdata = 32'd0; lsu_wmask = 4'd0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = 32'd0;
        cyc = 0; t_acc = 0; rdy_cyc = 0; rsp_cyc = 0; p_cyc = 0;
        own_lsu = 1'b0; exp_err = 1'b0; exp_rd = 32'd0; cur_mem_val = 32'd0;
        m_addr = 32'd0; m_wdata = 32'd0; m_wen = 1'b0; m_wmask = 4'd0;
        model_reset();
        rand_data();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        reset = 1'b0;

        // Single fetch with one-cycle memory.
        n_ifu_addr = 32'h8000_0000; n_mem_val = 32'h0010_0073;
        step(1'b1, 1'b0, 0, 0, 1'b0);
        idle(3, 1'b0, 1'b0);
        check("fetch_rdata", ifu_rdata, 32'h0010_0073);
        idle(1, 1'b0, 1'b0);

        // Both requesters held valid: grants alternate.
        idle(16, 1'b1, 1'b1);
        idle(1, 1'b0, 1'b0);

        // Store: fields pass through, rdata reads back 0.
        rand_data();
        n_lsu_addr = 32'h8000_1000; n_lsu_wdata = 32'hDEAD_BEEF; n_lsu_wmask = 4'hF; n_lsu_wen = 1'b1;
        step(1'b0, 1'b1, 0, 0, 1'b0);
        idle(4, 1'b0, 1'b0);

        // Load with a memory that never answers: timeout error.
        rand_data(); n_lsu_wen = 1'b0;
        step(1'b0, 1'b1, 50, 0, 1'b0);
        idle(5, 1'b0, 1'b0);

        // Ready held low while new requests keep arriving.
        rand_data();
        step(1'b1, 1'b0, 3, 0, 1'b0);
        idle(5, 1'b1, 1'b1);
        idle(2, 1'b0, 1'b0);

        // Reset while waiting in RSP.
        rand_data();
        step(1'b0, 1'b1, 0, 10, 1'b0);
        rand_data();
        step(1'b1, 1'b1, 0, 0, 1'b0);
        step(1'b1, 1'b1, 0, 0, 1'b0);
        #2 reset = 1'b1;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        cyc++;
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        reset = 1'b0;
        model_reset();
        step(1'b0, 1'b0, 0, 0, 1'b1);
        step(1'b0, 1'b0, 0, 0, 1'b1);
        step(1'b1, 1'b1, 0, 0, 1'b0);
        check("post_reset_grant", {31'd0, ifu_req_ready}, 32'd1);
        idle(4, 1'b0, 1'b0);

        // Randomized traffic with random memory delays and stray responses.
        for (int i = 0; i < 600; i++) begin
            rand_data();
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3), $urandom_range(0, 2), ($urandom_range(0, 3) == 0));
        end
        idle(6, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
